// File: rtl/mlp_serial_sched_if.sv
// rtl/mlp_serial_sched_if.sv - config, input and result handshake bundle for mlp_serial_sched
// MLP_SCORE_OUT_EN adds the out_score result field.
interface mlp_serial_sched_if #(
  parameter int N_IN = 21,
  parameter int IN_W = 4
);
  logic                   cfg_we;
  logic [6:0]             cfg_addr;
  logic [15:0]            cfg_wdata;
  logic                   cfg_err;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*IN_W-1:0]   inp;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_class;
  logic                   busy;
`ifdef MLP_SCORE_OUT_EN
  logic [24:0]            out_score;
`endif

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, inp, out_ready,
    output cfg_err, in_ready, out_valid, out_class, busy
`ifdef MLP_SCORE_OUT_EN
    , output out_score
`endif
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, inp, out_ready,
    input  cfg_err, in_ready, out_valid, out_class, busy
`ifdef MLP_SCORE_OUT_EN
    , input out_score
`endif
  );
endinterface

// File: rtl/mlp_serial_sched.sv
// rtl/mlp_serial_sched.sv - serial single-MAC scheduler for a 21-3-3 MLP with argmax output
// Optional MLP_SCORE_OUT_EN exposes the winning ReLU'd score on out_score.
module mlp_serial_sched #(
  parameter int N_IN  = 21,
  parameter int N_HID = 3,
  parameter int N_OUT = 3,
  parameter int IN_W  = 4,
  parameter int W_W   = 8,
  parameter int B0_W  = 12,
  parameter int B1_W  = 13,
  parameter int ACC_W = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  mlp_serial_sched_if.slave   bus
);
  localparam int A_W1  = N_HID * N_IN;
  localparam int A_B0  = A_W1 + N_OUT * N_HID;
  localparam int A_B1  = A_B0 + N_HID;
  localparam int A_END = A_B1 + N_OUT;
  localparam int I_W   = $clog2(N_IN);
  localparam int J_W   = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int W0_AW = $clog2(N_HID * N_IN);
  localparam int W1_AW = $clog2(N_OUT * N_HID);

  typedef enum logic [2:0] {S_IDLE, S_L0, S_L1, S_ARGMAX, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic signed [W_W-1:0]  r_w0 [N_HID*N_IN];
  logic signed [W_W-1:0]  r_w1 [N_OUT*N_HID];
  logic signed [B0_W-1:0] r_b0 [N_HID];
  logic signed [B1_W-1:0] r_b1 [N_OUT];
  logic [31:0]            r_h  [N_HID];
  logic [31:0]            r_s  [N_OUT];
  logic [N_IN*IN_W-1:0]   r_x;
  logic [I_W-1:0]         r_i;
  logic [J_W-1:0]         r_j;
  logic signed [ACC_W-1:0] r_acc, w_opx, w_opw, w_base, w_acc_nxt;
  logic [31:0]            w_relu, w_best;
  logic [1:0]             r_class, w_class;
  logic                   r_out_valid, r_cfg_err, w_last_i, w_last_j, w_cfg_bad;
`ifdef MLP_SCORE_OUT_EN
  logic [24:0]            r_score;
`endif

  always_comb begin
    w_opx  = '0;
    w_opw  = '0;
    w_base = r_acc;
    if (r_state == S_L1) begin
      w_opx = ACC_W'(r_h[r_i[J_W-1:0]]);
      w_opw = ACC_W'(r_w1[W1_AW'(int'(r_j) * N_HID + int'(r_i))]);
      if (r_i == '0) w_base = ACC_W'(r_b1[r_j]);
    end else begin
      w_opx = ACC_W'(r_x[r_i*IN_W +: IN_W]);
      w_opw = ACC_W'(r_w0[W0_AW'(int'(r_j) * N_IN + int'(r_i))]);
      if (r_i == '0) w_base = ACC_W'(r_b0[r_j]);
    end
    w_acc_nxt = w_base + w_opx * w_opw;
    w_relu    = w_acc_nxt[ACC_W-1] ? 32'd0 : w_acc_nxt[31:0];
  end

  assign w_last_i  = (r_state == S_L1) ? (r_i == I_W'(N_HID - 1)) : (r_i == I_W'(N_IN - 1));
  assign w_last_j  = (r_state == S_L1) ? (r_j == J_W'(N_OUT - 1)) : (r_j == J_W'(N_HID - 1));
  assign w_cfg_bad = (r_state != S_IDLE) || (int'(bus.cfg_addr) >= A_END);

  // Strict > keeps the lower index on ties; all-zero scores resolve to class 0.
  always_comb begin
    w_class = 2'd0;
    w_best  = r_s[0];
    if (r_s[1] > w_best) begin
      w_class = 2'd1;
      w_best  = r_s[1];
    end
    if (r_s[2] > w_best) begin
      w_class = 2'd2;
      w_best  = r_s[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.in_valid) w_state_nxt = S_L0;
      S_L0:     if (w_last_i && w_last_j) w_state_nxt = S_L1;
      S_L1:     if (w_last_i && w_last_j) w_state_nxt = S_ARGMAX;
      S_ARGMAX: w_state_nxt = S_DONE;
      S_DONE:   if (bus.out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_HID*N_IN; n++)  r_w0[n] <= '0;
      for (int n = 0; n < N_OUT*N_HID; n++) r_w1[n] <= '0;
      for (int n = 0; n < N_HID; n++) begin r_b0[n] <= '0; r_h[n] <= '0; end
      for (int n = 0; n < N_OUT; n++) begin r_b1[n] <= '0; r_s[n] <= '0; end
      r_x         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_acc       <= '0;
      r_class     <= '0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
`ifdef MLP_SCORE_OUT_EN
      r_score     <= '0;
`endif
    end else begin
      r_cfg_err <= bus.cfg_we && w_cfg_bad;
      if (bus.cfg_we && !w_cfg_bad) begin
        if (int'(bus.cfg_addr) < A_W1)
          r_w0[bus.cfg_addr[W0_AW-1:0]] <= bus.cfg_wdata[W_W-1:0];
        else if (int'(bus.cfg_addr) < A_B0)
          r_w1[W1_AW'(int'(bus.cfg_addr) - A_W1)] <= bus.cfg_wdata[W_W-1:0];
        else if (int'(bus.cfg_addr) < A_B1)
          r_b0[J_W'(int'(bus.cfg_addr) - A_B0)] <= bus.cfg_wdata[B0_W-1:0];
        else
          r_b1[J_W'(int'(bus.cfg_addr) - A_B1)] <= bus.cfg_wdata[B1_W-1:0];
      end
      unique case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_x <= bus.inp;
          r_i <= '0;
          r_j <= '0;
        end
        S_L0, S_L1: begin
          r_acc <= w_acc_nxt;
          if (w_last_i) begin
            r_i <= '0;
            r_j <= w_last_j ? '0 : r_j + 1'b1;
            if (r_state == S_L0) r_h[r_j] <= w_relu;
            else                 r_s[r_j] <= w_relu;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        S_ARGMAX: begin
          r_class     <= w_class;
          r_out_valid <= 1'b1;
`ifdef MLP_SCORE_OUT_EN
          r_score     <= w_best[24:0];
`endif
        end
        S_DONE: if (bus.out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = ^{w_acc_nxt[ACC_W-2:32], bus.cfg_wdata[15:B1_W]};

  assign bus.cfg_err   = r_cfg_err;
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_class = r_class;
`ifdef MLP_SCORE_OUT_EN
  assign bus.out_score = r_score;
`endif
endmodule

// File: tb/tb_mlp_serial_sched.sv
// tb/tb_mlp_serial_sched.sv - scoreboard bench for mlp_serial_sched
// Score checks are compiled in when MLP_SCORE_OUT_EN is defined.
module tb_mlp_serial_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mlp_serial_sched_if bus ();
  mlp_serial_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int cls; int score; } exp_t;
  exp_t q[$];
  int tw0 [63];
  int tw1 [9];
  int tb0 [3];
  int tb1 [3];
  int n_chk = 0;
  int n_pass = 0;
  logic [83:0] all_f;

  task automatic chk(input string tag, input longint obs, input longint req);
    n_chk++;
    if (obs === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, req);
  endtask

  task automatic clr_model();
    foreach (tw0[n]) tw0[n] = 0;
    foreach (tw1[n]) tw1[n] = 0;
    foreach (tb0[n]) tb0[n] = 0;
    foreach (tb1[n]) tb1[n] = 0;
  endtask

  function automatic void model(input logic [83:0] x, output int cls, output int score);
    int h[3];
    int s[3];
    int acc;
    for (int j = 0; j < 3; j++) begin
      acc = tb0[j];
      for (int i = 0; i < 21; i++) acc += int'(x[i*4 +: 4]) * tw0[j*21+i];
      h[j] = (acc < 0) ? 0 : acc;
    end
    for (int k = 0; k < 3; k++) begin
      acc = tb1[k];
      for (int j = 0; j < 3; j++) acc += h[j] * tw1[k*3+j];
      s[k] = (acc < 0) ? 0 : acc;
    end
    cls = 0;
    score = s[0];
    if (s[1] > score) begin cls = 1; score = s[1]; end
    if (s[2] > score) begin cls = 2; score = s[2]; end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_class", bus.out_class, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_model();
  endtask

  task automatic cfg_write(input int addr, input int val, input bit exp_err);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 7'(addr);
    bus.cfg_wdata = 16'(val);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    chk("cfg_err", bus.cfg_err, longint'(exp_err));
    if (!exp_err) begin
      if (addr < 63)      tw0[addr] = val;
      else if (addr < 72) tw1[addr-63] = val;
      else if (addr < 75) tb0[addr-72] = val;
      else                tb1[addr-75] = val;
    end
  endtask

  task automatic run_inf(input logic [83:0] x, input int hold, input bit busy_wr);
    exp_t e;
    int lat;
    model(x, e.cls, e.score);
    q.push_back(e);
    @(negedge clk);
    bus.inp = x;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100 && !bus.in_ready; t++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.inp = ~x;
    lat = 0;
    for (int t = 1; t <= 200; t++) begin
      @(posedge clk);
      #1;
      if (busy_wr && t == 10) begin
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 7'd0;
        bus.cfg_wdata = 16'd5;
      end
      if (busy_wr && t == 11) begin
        chk("busy_cfg_err", bus.cfg_err, 1);
        bus.cfg_we = 1'b0;
      end
      if (busy_wr && t == 12) chk("busy_cfg_err_end", bus.cfg_err, 0);
      if (bus.out_valid) begin
        lat = t;
        break;
      end
    end
    chk("latency", lat, 73);
    if (lat == 0) begin
      void'(q.pop_front());
      return;
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_class", bus.out_class, q[0].cls);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    e = q.pop_front();
    chk("class", bus.out_class, e.cls);
`ifdef MLP_SCORE_OUT_EN
    chk("score", bus.out_score, e.score);
`endif
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("consumed_valid", bus.out_valid, 0);
    chk("consumed_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_abort(input logic [83:0] x);
    int seen;
    @(negedge clk);
    bus.inp = x;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr_model();
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
  endtask

  function automatic logic [83:0] rand_x();
    logic [83:0] v;
    for (int i = 0; i < 21; i++) v[i*4 +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.in_valid = 1'b0;
    bus.inp = '0;
    bus.out_ready = 1'b0;
    all_f = {84{1'b1}};

    do_reset();
    cfg_write(80, 123, 1'b1);
    @(negedge clk);
    chk("err_pulse_end", bus.cfg_err, 0);
    chk("err_in_ready", bus.in_ready, 1);
    chk("err_busy", bus.busy, 0);

    cfg_write(72, -73, 1'b0);
    cfg_write(73, 748, 1'b0);
    cfg_write(74, 1077, 1'b0);
    cfg_write(75, -1547, 1'b0);
    cfg_write(76, 902, 1'b0);
    cfg_write(77, -2131, 1'b0);
    run_inf(rand_x(), 0, 1'b0);

    do_reset();
    cfg_write(0, 1, 1'b0);
    cfg_write(69, 2, 1'b0);
    run_inf(all_f, 0, 1'b0);
    cfg_write(0, -1, 1'b0);
    run_inf(all_f, 0, 1'b0);

    do_reset();
    for (int k = 0; k < 3; k++) cfg_write(75 + k, 5, 1'b0);
    run_inf(rand_x(), 0, 1'b0);
    cfg_write(75, 0, 1'b0);
    cfg_write(76, 7, 1'b0);
    cfg_write(77, 7, 1'b0);
    run_inf(rand_x(), 0, 1'b0);

    cfg_write(63, 1, 1'b0);
    run_inf(all_f, 10, 1'b1);
    run_inf(all_f, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 72; a++) cfg_write(a, int'($urandom_range(0, 255)) - 128, 1'b0);
      for (int a = 72; a < 75; a++) cfg_write(a, int'($urandom_range(0, 4095)) - 2048, 1'b0);
      for (int a = 75; a < 78; a++) cfg_write(a, int'($urandom_range(0, 8191)) - 4096, 1'b0);
      run_inf(rand_x(), 2, 1'b0);
    end

    run_abort(all_f);
    run_inf(all_f, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
